pipe_hazard_ctrl: RTL



---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, default register-index width and the control-word layout.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // One bit per pipeline control line driven by the sequencer.
  typedef struct packed {
    logic dmem_req;
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // Everything off: used under reset and in the error state.
  localparam ctrl_t CTRL_NOP = '0;

  // Free-running pipe: every register advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{
    dmem_req:     1'b0,
    pc_write:     1'b1,
    ifid_write:   1'b1,
    idex_write:   1'b1,
    exmem_write:  1'b1,
    ifid_flush:   1'b0,
    idex_bubble:  1'b0,
    memwb_bubble: 1'b0
  };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-register controls between
// the datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = pipe_pkg::REG_AW_DEF
);

  logic              idex_memread_i;
  logic [REG_AW-1:0] idex_rd_i;
  logic [REG_AW-1:0] ifid_rs_i;
  logic [REG_AW-1:0] ifid_rt_i;
  logic              ifid_uses_rt_i;
  logic              branch_taken_i;
  logic              exmem_memaccess_i;
  logic              dmem_ready_i;

  logic              dmem_req_o;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              idex_write_o;
  logic              exmem_write_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic              memwb_bubble_o;
  logic              err_o;

  modport master (
    output idex_memread_i, idex_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, exmem_memaccess_i, dmem_ready_i,
    input  dmem_req_o, pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
           ifid_flush_o, idex_bubble_o, memwb_bubble_o, err_o
  );

  modport slave (
    input  idex_memread_i, idex_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, exmem_memaccess_i, dmem_ready_i,
    output dmem_req_o, pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
           ifid_flush_o, idex_bubble_o, memwb_bubble_o, err_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID is about to read. Register 0 is hard-wired and never
// produces a dependency.
module hazard_detect #(
  parameter int REG_AW = pipe_pkg::REG_AW_DEF
) (
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_uses_rt_i,
  output logic              load_use_o
);

  logic rd_live;
  logic rs_hit;
  logic rt_hit;

  assign rd_live    = idex_memread_i && (idex_rd_i != '0);
  assign rs_hit     = (idex_rd_i == ifid_rs_i);
  assign rt_hit     = ifid_uses_rt_i && (idex_rd_i == ifid_rt_i);
  assign load_use_o = rd_live && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Freezes the pipe
// around multi-cycle data-memory accesses, inserts load-use bubbles,
// flushes IF/ID on taken branches and latches a sticky error when a memory
// access never completes.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_hazard_ctrl_if.slave   bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] wcnt_q;
  logic             err_q;

  logic  live;
  logic  mem_stall;
  logic  load_use;
  ctrl_t ctrl;

  // A request that is not acknowledged this cycle holds the whole pipe.
  assign mem_stall = bus.exmem_memaccess_i && !bus.dmem_ready_i;

  // RUN and MEM_WAIT drive the pipe; ERR and unused encodings shut it down.
  assign live = (state_q == RUN) || (state_q == MEM_WAIT);

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .idex_memread_i (bus.idex_memread_i),
    .idex_rd_i      (bus.idex_rd_i),
    .ifid_rs_i      (bus.ifid_rs_i),
    .ifid_rt_i      (bus.ifid_rt_i),
    .ifid_uses_rt_i (bus.ifid_uses_rt_i),
    .load_use_o     (load_use)
  );

  // Resolve this cycle's controls: reset, error, memory stall, load-use, branch.
  always_comb begin
    // NOTE: start from a full default so no path leaves a bit unassigned,
    // which would otherwise infer a latch.
    ctrl          = CTRL_RUN;
    ctrl.dmem_req = bus.exmem_memaccess_i;
    if (rst_i || !live) begin
      ctrl = CTRL_NOP;
    end else if (mem_stall) begin
      ctrl.pc_write     = 1'b0;
      ctrl.ifid_write   = 1'b0;
      ctrl.idex_write   = 1'b0;
      ctrl.exmem_write  = 1'b0;
      ctrl.memwb_bubble = 1'b1;
    end else if (load_use) begin
      // A branch seen alongside the hazard re-resolves once ID is replayed.
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end else if (bus.branch_taken_i) begin
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign bus.dmem_req_o     = ctrl.dmem_req;
  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.ifid_write_o   = ctrl.ifid_write;
  assign bus.idex_write_o   = ctrl.idex_write;
  assign bus.exmem_write_o  = ctrl.exmem_write;
  assign bus.ifid_flush_o   = ctrl.ifid_flush;
  assign bus.idex_bubble_o  = ctrl.idex_bubble;
  assign bus.memwb_bubble_o = ctrl.memwb_bubble;
  assign bus.err_o          = err_q;

  // Memory-wait FSM with watchdog; ERR is left only through reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order; the reset is
    // synchronous, so it is tested inside the clocked block only.
    if (rst_i) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEM_WAIT;
            wcnt_q  <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state_q <= RUN;
            wcnt_q  <= '0;
          end else if (wcnt_q == CNT_W'(WAIT_LIMIT)) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Profile counters: frozen-PC cycles outside ERR, and IF/ID flushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (live && !ctrl.pc_write) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ctrl.ifid_flush)        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
